// File: rtl/fpdivsqrt_pkg.sv
// Shared types and constants for the FP divide/sqrt sequencer.
package fpdivsqrt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_MULQ, ST_MULD, ST_MULR,
    ST_REM, ST_ROUND, ST_SPECIAL, ST_DONE
  } state_e;

  localparam logic [1:0] SEL_Q   = 2'd0;
  localparam logic [1:0] SEL_D   = 2'd1;
  localparam logic [1:0] SEL_R   = 2'd2;
  localparam logic [1:0] SEL_REM = 2'd3;

  localparam int K_DIV  = 2;
  localparam int K_SQRT = 3;

  typedef struct packed {
    logic       sqrt;
    logic       prec;
    logic [1:0] rmode;
  } op_req_t;

  // Start-to-done cycles for a normal (non-special) operation.
  function automatic int op_latency(input int iters, input logic sqrt, input int mul_lat);
    return 2 + mul_lat * (iters * (sqrt ? K_SQRT : K_DIV) + 1);
  endfunction

endpackage

// File: rtl/fpdivsqrt_waitcnt.sv
// Dwell counter for one multiplier pass: first/last pulses over MUL_LAT cycles.
// Wraps on the last cycle (the state changes there) and clears on flush or when idle.
module fpdivsqrt_waitcnt #(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic first,
  output logic last
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt <= '0;
    else if (clr || !en || last)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign first = en && (cnt == '0);
  assign last  = en && (cnt == CNT_LAST);

endmodule

// File: rtl/fpdivsqrt_seq.sv
// Multicycle sequencer for the Goldschmidt FP divide/sqrt datapath.
// Optional perf counters under `FPDIVSQRT_PERF_EN.
module fpdivsqrt_seq
  import fpdivsqrt_pkg::*;
#(
  parameter int ITER_DP = 4,
  parameter int ITER_SP = 3,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op_sqrt,
  input  logic        P,
  input  logic [1:0]  rm,
  input  logic [2:0]  sel_inv,
  input  logic        flush,
  input  logic        stall,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        ld_op,
  output logic [1:0]  mul_sel,
  output logic        mul_start,
  output logic        ld_mul,
  output logic [2:0]  iter_cnt,
  output logic        ld_result,
  output logic        P_q,
  output logic [1:0]  rm_q,
  output logic        sqrt_q
`ifdef FPDIVSQRT_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_cycles
`endif
);

  localparam logic [2:0] LAST_IT_DP = 3'(ITER_DP - 1);
  localparam logic [2:0] LAST_IT_SP = 3'(ITER_SP - 1);

  state_e  state;
  op_req_t req;
  logic    spc_hold;
  logic    in_mul, w_first, w_last, last_iter;

  assign in_mul    = state inside {ST_MULQ, ST_MULD, ST_MULR, ST_REM};
  assign last_iter = iter_cnt == (req.prec ? LAST_IT_SP : LAST_IT_DP);

  fpdivsqrt_waitcnt #(.MUL_LAT(MUL_LAT)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (in_mul),
    .clr     (flush),
    .first   (w_first),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      req      <= '0;
      iter_cnt <= '0;
      spc_hold <= 1'b0;
    end else if (flush && state != ST_IDLE) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      spc_hold <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start && !flush) begin
          req.sqrt  <= op_sqrt;
          req.prec  <= P;
          req.rmode <= rm;
          iter_cnt  <= '0;
          state     <= (sel_inv != 3'b000) ? ST_SPECIAL : ST_INIT;
        end
        ST_INIT: begin
          iter_cnt <= '0;
          state    <= ST_MULQ;
        end
        ST_MULQ: if (w_last) state <= ST_MULD;
        // An iteration ends after MULD (divide) or MULR (sqrt).
        ST_MULD, ST_MULR: if (w_last) begin
          if (state == ST_MULD && req.sqrt) state <= ST_MULR;
          else if (last_iter)               state <= ST_REM;
          else begin
            iter_cnt <= iter_cnt + 3'd1;
            state    <= ST_MULQ;
          end
        end
        ST_REM:   if (w_last) state <= ST_ROUND;
        ST_ROUND: state <= ST_DONE;
        // Special results take two cycles; the rounder is loaded on the second.
        ST_SPECIAL: begin
          spc_hold <= ~spc_hold;
          if (spc_hold) state <= ST_DONE;
        end
        ST_DONE:  if (!stall) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_sel = SEL_Q;
    case (state)
      ST_MULD: mul_sel = SEL_D;
      ST_MULR: mul_sel = SEL_R;
      ST_REM:  mul_sel = SEL_REM;
      default: mul_sel = SEL_Q;
    endcase
  end

  assign ready     = state == ST_IDLE;
  assign busy      = state != ST_IDLE;
  assign done      = state == ST_DONE;
  assign ld_op     = state == ST_INIT;
  assign mul_start = w_first;
  assign ld_mul    = w_last;
  assign ld_result = !flush && (state == ST_ROUND || (state == ST_SPECIAL && spc_hold));
  assign P_q       = req.prec;
  assign rm_q      = req.rmode;
  assign sqrt_q    = req.sqrt;

`ifdef FPDIVSQRT_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops    <= '0;
      perf_cycles <= '0;
    end else begin
      if (busy)                         perf_cycles <= perf_cycles + 32'd1;
      if (done && (!stall || flush))    perf_ops    <= perf_ops + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fpdivsqrt_seq.md
Name: fpdivsqrt_seq

Overview:
Multicycle sequencer for the FP divide/sqrt unit. It accepts one operation at a time, steps the shared multiplier through the Goldschmidt iterations, then runs the remainder step and the rounder, and finally hands the result back to the FPU.
- Produces all load enables, multiplier operand selects and the iteration count for the datapath.
- Latches the op, precision and rounding mode for the rounder.
- Special operands (NaN, Inf, zero, divide-by-zero) bypass the iterations.

Parameters:
ITER_DP, 4, number of Goldschmidt iterations for double precision
ITER_SP, 3, number of Goldschmidt iterations for single precision
MUL_LAT, 2, shared multiplier latency in cycles (must be ≥1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request a new operation; accepted only when ready=1
op_sqrt  in  1  0=divide, 1=square root
P  in  1  precision, 1=single, 0=double
rm  in  2  rounding mode (00 RNE, 01 RZ, 10 RU, 11 RD)
sel_inv  in  3  special-case code from operand classification; 000 = normal
flush  in  1  abort the current operation
stall  in  1  consumer not ready; holds DONE
ready  out  1  idle and able to accept start
busy  out  1  operation in flight (any state other than IDLE)
done  out  1  result and flags valid
ld_op  out  1  load operands and the initial approximation
mul_sel  out  2  multiplier operand select: 0=Q, 1=D, 2=R (sqrt only), 3=REM
mul_start  out  1  issue to the multiplier
ld_mul  out  1  capture multiplier output into the register chosen by mul_sel
iter_cnt  out  3  current iteration index
ld_result  out  1  capture the rounder Result/Flags
P_q  out  1  latched precision
rm_q  out  2  latched rounding mode
sqrt_q  out  1  latched op

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, ready=1.
  - All other outputs 0, including iter_cnt and the latched fields.
- States: IDLE, INIT, MULQ, MULD, MULR, REM, ROUND, SPECIAL, DONE.
- IDLE:
  - ready=1.
  - start=1 latches op_sqrt, P and rm.
  - If sel_inv≠000, next state is SPECIAL; otherwise INIT.
- INIT: ld_op=1 for 1 cycle, iter_cnt=0, then MULQ.
- MUL states (MULQ, MULD, MULR, REM):
  - Each lasts exactly MUL_LAT cycles.
  - mul_start=1 in the first cycle; ld_mul=1 in the last cycle.
  - mul_sel is constant for the whole state.
- Iteration sequence:
  - Divide: MULQ→MULD.
  - Sqrt: MULQ→MULD→MULR.
  - At the end of the last state of an iteration, iter_cnt increments.
  - When iter_cnt reaches ITERS-1 (ITERS = P_q ? ITER_SP : ITER_DP), the next state is REM instead of MULQ.
- REM: drives the remainder multiply (mul_sel=3), then ROUND.
- ROUND: ld_result=1 for 1 cycle, then DONE.
- SPECIAL: ld_result=1 for 1 cycle, no multiplier activity, then DONE.
- DONE:
  - done=1.
  - stall=1 holds DONE; otherwise next state is IDLE.
  - done never coincides with ready.
- Latency, measured from the start-accepting edge to done high:
  - Normal operation: L = 2 + MUL_LAT·(ITERS·K + 1), with K=2 for divide and K=3 for sqrt.
  - Defaults give: DP div 20, SP div 16, DP sqrt 28, SP sqrt 22.
  - SPECIAL path: 2.
- flush:
  - In any non-IDLE state, the next state is IDLE.
  - No ld_result or done is produced.
  - Counters are cleared.
  - flush beats start in the same cycle.
- start while busy is ignored; no queueing.
- reset_n asserted mid-operation: immediate return to reset values.

Optional Feature:
FPDIVSQRT_PERF_EN
- Defined: adds output ports perf_ops (32 bits) and perf_cycles (32 bits).
  - perf_ops increments on each DONE exit.
  - perf_cycles increments on each busy cycle.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fpdivsqrt_pkg holds:
  - state enum;
  - mul_sel encodings (SEL_Q, SEL_D, SEL_R, SEL_REM);
  - the K constants for divide and sqrt;
  - the latency helper function.
- Sub-module fpdivsqrt_waitcnt:
  - counts MUL_LAT cycles;
  - emits first and last pulses;
  - clears on state change or flush.

Test Plan:
- DP divide, P=0, sel_inv=000, defaults → done at +20 cycles; ld_mul pulses 9 times; iter_cnt goes 0..3; ld_result exactly once.
- SP sqrt, P=1 → done at +22 cycles; mul_sel sequence 0,1,2 repeated 3 times then 3.
- sel_inv=110 (div-by-zero) → SPECIAL path, done at +2 cycles; no mul_start.
- flush asserted at cycle 7 of a DP divide → next cycle IDLE, ready=1; no done/ld_result; a new start then completes in 20 cycles.
- stall=1 for 5 cycles during DONE → done held 6 cycles; a start during those cycles is ignored.
- reset_n pulsed low mid-MULD → all outputs 0 and ready=1 immediately. With FPDIVSQRT_PERF_EN defined, the counters read 0.
